// File: rtl/mul16_seq_ctrl_pkg.sv
// Shared constants and types for the sequential 16-bit shift-and-add multiplier.
// Holds the controller state encoding and the fixed iteration count.
package mul16_seq_ctrl_pkg;

    localparam int MUL_W    = 16;
    localparam int MUL_ITER = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul16_seq_ctrl_adder16.sv
// 16-bit adder shared by the multiplier datapath; the carry-out is intentionally dropped
// because only the low 16 bits of the product are kept.
module mul16_seq_ctrl_adder16
    import mul16_seq_ctrl_pkg::*;
(
    input  logic [MUL_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    output logic [MUL_W-1:0] out
);

    assign out = a + b;

endmodule

// File: rtl/mul16_seq_ctrl.sv
// Multi-cycle multiply unit: out = (a * b) mod 2^16 via 16 shift-and-add passes
// through a single shared adder, with a start/busy/done handshake.
module mul16_seq_ctrl
    import mul16_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   sum;

    mul16_seq_ctrl_adder16 u_adder16 (
        .a   (acc),
        .b   (mcand),
        .out (sum)
    );

    // Decodes of the registered state only, so neither output can glitch.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= a;
                        mplier <= b;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= sum;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    // Last pass: publish the accumulator including this edge's add.
                    if (cnt == CNT_W'(MUL_ITER - 1)) begin
                        out   <= mplier[0] ? sum : acc;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
